dcache_axi_master: RTL and testbench
====================================

# dcache_axi_master

Downstream AXI4 master for the L1 data cache. Converts the cache's memory-side request interface (`D_req`, `D_write`, `D_addr`, `D_in`, `D_type`) into AXI read and write transactions:
- 4-beat INCR line fills for cacheable reads.
- Single-beat reads and writes for everything else.

It returns read data and the `RVALID`/`RLAST`/`BVALID`/`BREADY` indications the cache state machine consumes, and sits between the data cache and the bus interconnect.

## Interface
- `ID_VAL`, default 4'd1: constant driven on `AWID`/`ARID`.
- `clk`  in  1  system clock; all flops rise-edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `D_req`  in  1  read request from cache; held until the final read beat.
- `D_write`  in  1  write request; held until the B handshake.
- `D_addr`  in  32  byte address; line-aligned for fills.
- `D_in`  in  32  write data, already lane-aligned.
- `D_type`  in  3  access type: 000 byte, 001 half, 010 word, 100 byte_u, 101 half_u.
- `D_out`  out  32  read data (= `RDATA` while in R_DATA, else 0).
- `RVALID_c`, `RLAST_c`  out  1  read beat valid / last beat, to cache.
- `BVALID_c`, `BREADY_c`  out  1  write response indications, to cache.
- `bus_err`  out  1  sticky error flag; cleared only by reset.
- AR channel: `ARID`[3:0], `ARADDR`[31:0], `ARLEN`[3:0], `ARSIZE`[2:0], `ARBURST`[1:0], `ARVALID` out; `ARREADY` in.
- R channel: `RID`[3:0], `RDATA`[31:0], `RRESP`[1:0], `RLAST`, `RVALID` in; `RREADY` out.
- AW channel: `AWID`, `AWADDR`, `AWLEN`, `AWSIZE`, `AWBURST`, `AWVALID` out (same widths as AR); `AWREADY` in.
- W channel: `WDATA`[31:0], `WSTRB`[3:0], `WLAST`, `WVALID` out; `WREADY` in.
- B channel: `BID`[3:0], `BRESP`[1:0], `BVALID` in; `BREADY` out.

## Operation
**States:** IDLE, AR, R_DATA, AW_W, B_RESP.

**IDLE**
- Sample the request:
  - `D_write`=1 → latch `D_addr`, `D_in`, `D_type`; go to AW_W. `D_write` has priority over `D_req`.
  - else `D_req`=1 → latch `D_addr`; go to AR.
- Cacheable = `addr[31:16]` ∉ {16'h1000, 16'h6000}.

**AR**
- `ARVALID`=1.
- `ARADDR` = latched address, with `[3:0]` zeroed when cacheable.
- `ARLEN` = 3 if cacheable, else 0.
- `ARSIZE`=3'b010, `ARBURST`=2'b01 (INCR).
- On `ARREADY` → R_DATA; beat counter cleared to 0; expected-last count loaded with `ARLEN`.

**R_DATA**
- `RREADY`=1.
- `RVALID_c`=`RVALID`; `RLAST_c`=`RVALID`&`RLAST`; `D_out`=`RDATA`.
- Each `RVALID` increments the 2-bit beat counter.
- Protocol error (sets `bus_err`, transaction still completes):
  - `RLAST` on a beat ≠ expected count, or
  - `RRESP`≠00, or
  - `RID`≠`ID_VAL`.
- `RVALID`&`RLAST` → IDLE.

**AW_W**
- `AWVALID` and `WVALID` are raised together. Each drops independently after its own handshake, tracked by flags `aw_done`/`w_done`.
- `AWADDR` = latched address; `AWLEN`=0; `AWSIZE`=010; `WLAST`=1; `WDATA` = latched `D_in`.
- `WSTRB` from type and `addr[1:0]`:
  - byte: `4'b0001<<a[1:0]`.
  - half: `4'b0011<<{a[1],1'b0}`.
  - word: `4'b1111`.
  - other encodings: `4'b0000` and set `bus_err`.
- Both handshakes complete (either order, or the same cycle) → B_RESP.

**B_RESP**
- `BREADY`=1; `BREADY_c`=1; `BVALID_c`=`BVALID`.
- On `BVALID` → IDLE. `BRESP`≠00 or `BID`≠`ID_VAL` sets `bus_err`.

**Outputs and reset**
- All AXI outputs and `*_c` outputs are 0 outside the states listed above.
- `bus_err` is set by any error condition above and held until reset.
- Reset (any state, including mid-burst): state=IDLE; every VALID/READY output 0; `D_out`=0; `bus_err`=0; latches and counters 0. No outstanding transaction is remembered.

## Timing
- Request accepted in IDLE at edge N; `ARVALID`/`AWVALID` high from cycle N+1.
- Read: `D_out`/`RVALID_c` are combinational from R inputs, giving zero added latency per beat.
  - Best-case line fill: 1 (accept) + 1 (AR) + 4 beats = 6 cycles.
- Write best case: accept, AW+W handshake, B in the following cycle = 3 cycles.
- VALID signals are never dropped before their handshake. Address and data are stable while VALID=1.
- IDLE is re-entered for at least one cycle between transactions. The cache has deasserted its request by then.
- No outstanding-transaction overlap: at most one transaction in flight.

## Test plan
- Cacheable read at 0x0000_2348, `ARREADY` after 2 cycles, R beats 0xA0..0xA3 with one `RVALID` bubble → `ARADDR`=0x0000_2340, `ARLEN`=3; `D_out` carries each beat; `RLAST_c` only on 0xA3; returns to IDLE; `bus_err`=0.
- Uncacheable read at 0x1000_0004 → `ARLEN`=0, `ARADDR`=0x1000_0004; single beat with `RLAST` → IDLE.
- Byte write to 0x6000_0003, `D_in`=0xDD00_0000; `WREADY` 3 cycles before `AWREADY` → `WSTRB`=4'b1000; `WVALID` drops after its handshake while `AWVALID` stays high; `BREADY_c`=1 and IDLE after `BVALID`.
- Half write to 0x0000_0102, with AW and W accepted in the same cycle → `WSTRB`=4'b1100; B_RESP entered the next cycle.
- Line fill with `RLAST` on beat 2, then a separate write with `BRESP`=2'b10 → `bus_err` set, each transaction still completes, and `bus_err` stays 1.
- Assert `rst_n`=0 during beat 1 of a fill → all VALID/READY outputs 0 immediately; IDLE after release; a new read issues normally.

Source files
------------

// File: rtl/dcache_axi_master.sv
// AXI4 master for the L1 D-cache: 4-beat INCR fills for cacheable reads, single beats otherwise.
// Latency: AR/AW valid one cycle after request accept; R data passes through combinationally.
// Backpressure: VALIDs held until handshake; at most one transaction in flight.
module dcache_axi_master #(
  parameter logic [3:0] ID_VAL = 4'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        D_req,
  input  logic        D_write,
  input  logic [31:0] D_addr,
  input  logic [31:0] D_in,
  input  logic [2:0]  D_type,
  output logic [31:0] D_out,
  output logic        RVALID_c,
  output logic        RLAST_c,
  output logic        BVALID_c,
  output logic        BREADY_c,
  output logic        bus_err,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_RDATA, S_AWW, S_BRESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dat;
    logic [2:0]  typ;
  } req_t;

  state_t     state_q, state_d;
  req_t       req_q, req_d;
  logic [1:0] beat_q, beat_d;
  logic [1:0] exp_last_q, exp_last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       bus_err_q, bus_err_d;

  logic       cacheable;
  logic [3:0] arlen;
  logic [3:0] wstrb;
  logic       type_err;
  logic       in_ar, in_r, in_w, in_b;

  always_comb begin
    cacheable = !((req_q.addr[31:16] == 16'h1000) || (req_q.addr[31:16] == 16'h6000));
    arlen     = cacheable ? 4'd3 : 4'd0;
    type_err  = 1'b0;
    case (req_q.typ)
      3'b000:  wstrb = 4'b0001 << req_q.addr[1:0];
      3'b001:  wstrb = 4'b0011 << {req_q.addr[1], 1'b0};
      3'b010:  wstrb = 4'b1111;
      default: begin
        wstrb    = 4'b0000;
        type_err = 1'b1;
      end
    endcase
  end

  assign in_ar = (state_q == S_AR);
  assign in_r  = (state_q == S_RDATA);
  assign in_w  = (state_q == S_AWW);
  assign in_b  = (state_q == S_BRESP);

  assign ARID     = ID_VAL;
  assign ARVALID  = in_ar;
  assign ARADDR   = in_ar ? (cacheable ? {req_q.addr[31:4], 4'h0} : req_q.addr) : 32'h0;
  assign ARLEN    = in_ar ? arlen : 4'd0;
  assign ARSIZE   = in_ar ? 3'b010 : 3'b000;
  assign ARBURST  = in_ar ? 2'b01 : 2'b00;

  // Read beats are forwarded straight through so the cache sees no extra latency.
  assign RREADY   = in_r;
  assign RVALID_c = in_r & RVALID;
  assign RLAST_c  = in_r & RVALID & RLAST;
  assign D_out    = in_r ? RDATA : 32'h0;

  assign AWID     = ID_VAL;
  assign AWVALID  = in_w & ~aw_done_q;
  assign AWADDR   = in_w ? req_q.addr : 32'h0;
  assign AWLEN    = 4'd0;
  assign AWSIZE   = in_w ? 3'b010 : 3'b000;
  assign AWBURST  = in_w ? 2'b01 : 2'b00;
  assign WVALID   = in_w & ~w_done_q;
  assign WDATA    = in_w ? req_q.dat : 32'h0;
  assign WSTRB    = in_w ? wstrb : 4'b0000;
  assign WLAST    = in_w;

  assign BREADY   = in_b;
  assign BREADY_c = in_b;
  assign BVALID_c = in_b & BVALID;
  assign bus_err  = bus_err_q;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    beat_d     = beat_q;
    exp_last_d = exp_last_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (D_write) begin
          req_d     = '{addr: D_addr, dat: D_in, typ: D_type};
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_AWW;
        end else if (D_req) begin
          req_d.addr = D_addr;
          state_d    = S_AR;
        end
      end
      S_AR: begin
        if (ARREADY) begin
          beat_d     = 2'd0;
          exp_last_d = arlen[1:0];
          state_d    = S_RDATA;
        end
      end
      S_RDATA: begin
        if (RVALID) begin
          beat_d = beat_q + 2'd1;
          if ((RLAST && (beat_q != exp_last_q)) || (RRESP != 2'b00) || (RID != ID_VAL))
            bus_err_d = 1'b1;
          if (RLAST)
            state_d = S_IDLE;
        end
      end
      S_AWW: begin
        aw_done_d = aw_done_q | (AWVALID & AWREADY);
        w_done_d  = w_done_q | (WVALID & WREADY);
        if (type_err)
          bus_err_d = 1'b1;
        if (aw_done_d && w_done_d)
          state_d = S_BRESP;
      end
      S_BRESP: begin
        if (BVALID) begin
          if ((BRESP != 2'b00) || (BID != ID_VAL))
            bus_err_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      beat_q     <= 2'd0;
      exp_last_q <= 2'd0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      beat_q     <= beat_d;
      exp_last_q <= exp_last_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_dcache_axi_master.sv
// Directed bench for dcache_axi_master: fills, single reads, strobed writes, errors, mid-burst reset.
// Inputs driven 2ns after the rising edge, outputs sampled 1ns later.
module tb_dcache_axi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        D_req, D_write;
  logic [31:0] D_addr, D_in;
  logic [2:0]  D_type;
  logic [31:0] D_out;
  logic        RVALID_c, RLAST_c, BVALID_c, BREADY_c, bus_err;
  logic [3:0]  ARID, ARLEN, AWID, AWLEN;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, AWBURST;
  logic        ARVALID, ARREADY, AWVALID, AWREADY;
  logic [3:0]  RID, BID, WSTRB;
  logic [31:0] RDATA;
  logic [1:0]  RRESP, BRESP;
  logic        RLAST, RVALID, RREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dcache_axi_master #(.ID_VAL(4'd1)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_req(D_req), .D_write(D_write), .D_addr(D_addr), .D_in(D_in), .D_type(D_type),
    .D_out(D_out), .RVALID_c(RVALID_c), .RLAST_c(RLAST_c), .BVALID_c(BVALID_c),
    .BREADY_c(BREADY_c), .bus_err(bus_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rbeat(input logic vld, input logic [31:0] dat, input logic last);
    RVALID = vld;
    RDATA  = dat;
    RLAST  = last;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    D_req = 1'b0; D_write = 1'b0; D_addr = '0; D_in = '0; D_type = 3'b010;
    ARREADY = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
    RID = 4'd1; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
    BID = 4'd1; BRESP = 2'b00; BVALID = 1'b0;

    #12;
    chk("rst_arvalid", {31'd0, ARVALID}, 32'd0);
    chk("rst_rready",  {31'd0, RREADY},  32'd0);
    chk("rst_awvalid", {31'd0, AWVALID}, 32'd0);
    chk("rst_wvalid",  {31'd0, WVALID},  32'd0);
    chk("rst_bready",  {31'd0, BREADY},  32'd0);
    chk("rst_dout",    D_out,            32'd0);
    chk("rst_buserr",  {31'd0, bus_err}, 32'd0);
    tick(); rst_n = 1'b1;

    // Cacheable line fill with delayed ARREADY and one R bubble
    tick(); D_req = 1'b1; D_addr = 32'h0000_2348;
    tick(); #1;
    chk("fill_arvalid", {31'd0, ARVALID}, 32'd1);
    chk("fill_araddr",  ARADDR, 32'h0000_2340);
    chk("fill_arlen",   {28'd0, ARLEN}, 32'd3);
    chk("fill_arsize",  {29'd0, ARSIZE}, 32'd2);
    chk("fill_arburst", {30'd0, ARBURST}, 32'd1);
    tick(); #1;
    chk("fill_arvalid_hold", {31'd0, ARVALID}, 32'd1);
    ARREADY = 1'b1;
    tick(); ARREADY = 1'b0;
    rbeat(1'b1, 32'hA0, 1'b0);
    chk("fill_rready", {31'd0, RREADY}, 32'd1);
    chk("fill_arvalid_drop", {31'd0, ARVALID}, 32'd0);
    chk("fill_b0", D_out, 32'hA0);
    chk("fill_b0_vld", {31'd0, RVALID_c}, 32'd1);
    chk("fill_b0_last", {31'd0, RLAST_c}, 32'd0);
    tick(); rbeat(1'b0, 32'h0, 1'b0);
    chk("fill_bubble_vld", {31'd0, RVALID_c}, 32'd0);
    tick(); rbeat(1'b1, 32'hA1, 1'b0);
    chk("fill_b1", D_out, 32'hA1);
    tick(); rbeat(1'b1, 32'hA2, 1'b0);
    chk("fill_b2", D_out, 32'hA2);
    chk("fill_b2_last", {31'd0, RLAST_c}, 32'd0);
    tick(); rbeat(1'b1, 32'hA3, 1'b1);
    chk("fill_b3", D_out, 32'hA3);
    chk("fill_b3_last", {31'd0, RLAST_c}, 32'd1);
    tick(); rbeat(1'b0, 32'h0, 1'b0); D_req = 1'b0;
    chk("fill_idle_rready", {31'd0, RREADY}, 32'd0);
    chk("fill_idle_dout", D_out, 32'd0);
    chk("fill_buserr", {31'd0, bus_err}, 32'd0);

    // Uncacheable single-beat read
    tick(); D_req = 1'b1; D_addr = 32'h1000_0004;
    tick(); #1;
    chk("unc_araddr", ARADDR, 32'h1000_0004);
    chk("unc_arlen", {28'd0, ARLEN}, 32'd0);
    ARREADY = 1'b1;
    tick(); ARREADY = 1'b0;
    rbeat(1'b1, 32'h1234_5678, 1'b1);
    chk("unc_dout", D_out, 32'h1234_5678);
    chk("unc_last", {31'd0, RLAST_c}, 32'd1);
    tick(); rbeat(1'b0, 32'h0, 1'b0); D_req = 1'b0;
    chk("unc_idle", {31'd0, RREADY}, 32'd0);
    chk("unc_buserr", {31'd0, bus_err}, 32'd0);

    // Byte write, W accepted three cycles before AW
    tick(); D_write = 1'b1; D_addr = 32'h6000_0003; D_in = 32'hDD00_0000; D_type = 3'b000;
    tick(); #1;
    chk("bw_awvalid", {31'd0, AWVALID}, 32'd1);
    chk("bw_wvalid",  {31'd0, WVALID}, 32'd1);
    chk("bw_wstrb",   {28'd0, WSTRB}, 32'h8);
    chk("bw_awaddr",  AWADDR, 32'h6000_0003);
    chk("bw_wdata",   WDATA, 32'hDD00_0000);
    chk("bw_wlast",   {31'd0, WLAST}, 32'd1);
    chk("bw_awlen",   {28'd0, AWLEN}, 32'd0);
    chk("bw_awsize",  {29'd0, AWSIZE}, 32'd2);
    WREADY = 1'b1;
    tick(); WREADY = 1'b0; #1;
    chk("bw_wvalid_drop", {31'd0, WVALID}, 32'd0);
    chk("bw_awvalid_hold1", {31'd0, AWVALID}, 32'd1);
    tick(); #1;
    chk("bw_awvalid_hold2", {31'd0, AWVALID}, 32'd1);
    chk("bw_bready_early", {31'd0, BREADY}, 32'd0);
    tick(); AWREADY = 1'b1;
    tick(); AWREADY = 1'b0; BVALID = 1'b1; #1;
    chk("bw_awvalid_drop", {31'd0, AWVALID}, 32'd0);
    chk("bw_bready", {31'd0, BREADY}, 32'd1);
    chk("bw_bready_c", {31'd0, BREADY_c}, 32'd1);
    chk("bw_bvalid_c", {31'd0, BVALID_c}, 32'd1);
    tick(); BVALID = 1'b0; D_write = 1'b0; #1;
    chk("bw_idle", {31'd0, BREADY}, 32'd0);
    chk("bw_buserr", {31'd0, bus_err}, 32'd0);

    // Half write, AW and W in the same cycle
    tick(); D_write = 1'b1; D_addr = 32'h0000_0102; D_in = 32'hBEEF_0000; D_type = 3'b001;
    tick(); #1;
    chk("hw_wstrb", {28'd0, WSTRB}, 32'hC);
    AWREADY = 1'b1; WREADY = 1'b1;
    tick(); AWREADY = 1'b0; WREADY = 1'b0; #1;
    chk("hw_bready_next", {31'd0, BREADY}, 32'd1);
    chk("hw_awvalid_drop", {31'd0, AWVALID}, 32'd0);
    chk("hw_wvalid_drop", {31'd0, WVALID}, 32'd0);
    BVALID = 1'b1;
    tick(); BVALID = 1'b0; D_write = 1'b0; #1;
    chk("hw_idle", {31'd0, BREADY}, 32'd0);

    // Fill with early RLAST, then a write with SLVERR
    tick(); D_req = 1'b1; D_addr = 32'h0000_0040;
    tick(); ARREADY = 1'b1;
    tick(); ARREADY = 1'b0; rbeat(1'b1, 32'hB0, 1'b0);
    tick(); rbeat(1'b1, 32'hB1, 1'b0);
    chk("erl_buserr_pre", {31'd0, bus_err}, 32'd0);
    tick(); rbeat(1'b1, 32'hB2, 1'b1);
    chk("erl_last", {31'd0, RLAST_c}, 32'd1);
    tick(); rbeat(1'b0, 32'h0, 1'b0); D_req = 1'b0;
    chk("erl_idle", {31'd0, RREADY}, 32'd0);
    chk("erl_buserr", {31'd0, bus_err}, 32'd1);
    tick(); D_write = 1'b1; D_addr = 32'h0000_0100; D_in = 32'h1122_3344; D_type = 3'b010;
    tick(); #1;
    chk("slv_wstrb", {28'd0, WSTRB}, 32'hF);
    AWREADY = 1'b1; WREADY = 1'b1;
    tick(); AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b1; BRESP = 2'b10; #1;
    chk("slv_bready", {31'd0, BREADY}, 32'd1);
    tick(); BVALID = 1'b0; BRESP = 2'b00; D_write = 1'b0; #1;
    chk("slv_idle", {31'd0, BREADY}, 32'd0);
    chk("slv_buserr", {31'd0, bus_err}, 32'd1);
    tick(); #1;
    chk("slv_buserr_sticky", {31'd0, bus_err}, 32'd1);

    // Reset during beat 1 of a fill
    tick(); D_req = 1'b1; D_addr = 32'h0000_0080;
    tick(); ARREADY = 1'b1;
    tick(); ARREADY = 1'b0; rbeat(1'b1, 32'hC0, 1'b0);
    tick(); rbeat(1'b1, 32'hC1, 1'b0);
    chk("mrst_pre_dout", D_out, 32'hC1);
    rst_n = 1'b0; #1;
    chk("mrst_rready", {31'd0, RREADY}, 32'd0);
    chk("mrst_rvalid_c", {31'd0, RVALID_c}, 32'd0);
    chk("mrst_dout", D_out, 32'd0);
    chk("mrst_arvalid", {31'd0, ARVALID}, 32'd0);
    chk("mrst_awvalid", {31'd0, AWVALID}, 32'd0);
    chk("mrst_wvalid", {31'd0, WVALID}, 32'd0);
    chk("mrst_bready", {31'd0, BREADY}, 32'd0);
    chk("mrst_buserr", {31'd0, bus_err}, 32'd0);
    RVALID = 1'b0; D_req = 1'b0;
    tick(); rst_n = 1'b1;
    tick(); #1;
    chk("mrst_idle_arvalid", {31'd0, ARVALID}, 32'd0);
    D_req = 1'b1; D_addr = 32'h1000_0010;
    tick(); #1;
    chk("post_arvalid", {31'd0, ARVALID}, 32'd1);
    chk("post_araddr", ARADDR, 32'h1000_0010);
    chk("post_arlen", {28'd0, ARLEN}, 32'd0);
    ARREADY = 1'b1;
    tick(); ARREADY = 1'b0; rbeat(1'b1, 32'hCAFE_F00D, 1'b1);
    chk("post_dout", D_out, 32'hCAFE_F00D);
    chk("post_last", {31'd0, RLAST_c}, 32'd1);
    tick(); rbeat(1'b0, 32'h0, 1'b0); D_req = 1'b0;
    chk("post_idle", {31'd0, RREADY}, 32'd0);
    chk("post_buserr", {31'd0, bus_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
